// File: rtl/axis_fifo_ctrl_if.sv
// Signal bundle between axis_fifo_ctrl, its push producer, its RAM and its AXIS consumer.
// The master modport is the controller's view; slave is the surrounding system's view.
interface axis_fifo_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int SIZE_LOG2 = 8
);
  logic [WIDTH-1:0]     idata;
  logic                 ienable;
  logic                 iafull;
  logic                 overflow;
  logic [SIZE_LOG2:0]   count;
  logic [SIZE_LOG2-1:0] ram_waddr;
  logic [WIDTH-1:0]     ram_wdata;
  logic                 ram_wenable;
  logic [SIZE_LOG2-1:0] ram_raddr;
  logic [WIDTH-1:0]     ram_rdata;
  logic [WIDTH-1:0]     odata;
  logic                 ovalid;
  logic                 oready;

  modport master (
    input  idata, ienable, ram_rdata, oready,
    output iafull, overflow, count, ram_waddr, ram_wdata, ram_wenable,
           ram_raddr, odata, ovalid
  );

  modport slave (
    output idata, ienable, ram_rdata, oready,
    input  iafull, overflow, count, ram_waddr, ram_wdata, ram_wenable,
           ram_raddr, odata, ovalid
  );
endinterface

// File: rtl/axis_fifo_ctrl.sv
// Push-in / AXI-Stream-out FIFO sequencer around an external registered-read dual-port RAM.
// Hides the RAM read latency behind an output register plus a one-entry skid register.
module axis_fifo_ctrl #(
  parameter int WIDTH        = 8,
  parameter int SIZE_LOG2    = 8,
  parameter int AFULL_MARGIN = 16
) (
  input logic              clock,
  input logic              resetn,
  axis_fifo_ctrl_if.master bus
);

  localparam logic [SIZE_LOG2:0] FULL_LEVEL  = (SIZE_LOG2+1)'(2**SIZE_LOG2);
  localparam logic [SIZE_LOG2:0] AFULL_LEVEL = (SIZE_LOG2+1)'(2**SIZE_LOG2 - AFULL_MARGIN);

  logic [SIZE_LOG2:0] wptr;
  logic [SIZE_LOG2:0] rptr;
  logic [SIZE_LOG2:0] count_q;
  logic [SIZE_LOG2:0] level;
  logic               overflow_q;
  logic               inflight;
  logic               skid_valid;
  logic [WIDTH-1:0]   skid_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               full;
  logic               push_ok;
  logic               xfer;
  logic               issue;
  logic [1:0]         pending;

  // Pending counts words already read out of the RAM but not yet handed to the consumer.
  always_comb begin
    full    = (count_q == FULL_LEVEL);
    push_ok = bus.ienable && !full;
    xfer    = out_valid && bus.oready;
    level   = wptr - rptr;
    pending = {1'b0, inflight} + {1'b0, skid_valid} + {1'b0, out_valid};
    issue   = (level != '0) && ((pending < 2'd2) || xfer);
  end

  assign bus.ram_wenable = push_ok;
  assign bus.ram_wdata   = bus.idata;
  assign bus.ram_waddr   = wptr[SIZE_LOG2-1:0];
  assign bus.ram_raddr   = rptr[SIZE_LOG2-1:0];
  assign bus.odata       = out_data;
  assign bus.ovalid      = out_valid;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.iafull      = (count_q >= AFULL_LEVEL);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (issue)   rptr <= rptr + 1'b1;
      inflight <= issue;
      if (bus.ienable && full) overflow_q <= 1'b1;
      case ({push_ok, xfer})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The skid word is always older than an arriving word, so it refills the output first.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (xfer) begin
      if (skid_valid) begin
        out_data <= skid_data;
        if (inflight) begin
          skid_data <= bus.ram_rdata;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (inflight) begin
        out_data <= bus.ram_rdata;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (inflight) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= bus.ram_rdata;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Scoreboard bench for axis_fifo_ctrl with a behavioural registered-read RAM.
// Stimulus pushes expected words into a queue; a negedge monitor pops on every AXIS transfer.
module tb_axis_fifo_ctrl;

  localparam int WIDTH        = 8;
  localparam int SIZE_LOG2    = 4;
  localparam int AFULL_MARGIN = 4;

  logic clock;
  logic resetn;
  int   errors;
  int   checks;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] ram_mem [0:(2**SIZE_LOG2)-1];
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;

  axis_fifo_ctrl_if #(.WIDTH(WIDTH), .SIZE_LOG2(SIZE_LOG2)) bus ();

  axis_fifo_ctrl #(
    .WIDTH(WIDTH), .SIZE_LOG2(SIZE_LOG2), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ram_wenable) ram_mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_raddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] data, input logic rdy, input logic accept);
    bus.ienable = en;
    bus.idata   = data;
    bus.oready  = rdy;
    if (en && accept) sb.push_back(data);
    @(posedge clock);
    #2;
  endtask

  task automatic drainAll();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    checkOutput("drain_count", 32'(bus.count), 32'd0);
  endtask

  // Monitor: every transfer must match the oldest expected word; a stalled beat must hold.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.ovalid === 1'b1 && bus.odata === prev_data)) begin
          errors++;
          $display("[TB] FAIL stall_hold: ovalid=%0b odata=0x%0h required ovalid=1 odata=0x%0h", bus.ovalid, bus.odata, prev_data);
        end
      end
      if (bus.ovalid && bus.oready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h with empty scoreboard", bus.odata);
        end else begin
          logic [WIDTH-1:0] exp_word;
          exp_word = sb.pop_front();
          if (bus.odata !== exp_word) begin
            errors++;
            $display("[TB] FAIL data_order: got 0x%0h expected 0x%0h", bus.odata, exp_word);
          end
        end
      end
      prev_stall = bus.ovalid && !bus.oready;
      prev_data  = bus.odata;
    end
  end

  initial begin
    errors       = 0;
    checks       = 0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    resetn       = 1'b0;
    bus.ienable  = 1'b1;
    bus.idata    = 8'h11;
    bus.oready   = 1'b0;
    #1;
    checkOutput("reset_ovalid", 32'(bus.ovalid), 32'd0);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    checkOutput("reset_odata", 32'(bus.odata), 32'd0);
    checkOutput("reset_wenable", 32'(bus.ram_wenable), 32'd1);
    bus.ienable = 1'b0;
    @(posedge clock); #2;
    resetn = 1'b1;

    // Mid-stream reset discards buffered words.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b0;
    sb.delete();
    #1;
    checkOutput("midreset_ovalid", 32'(bus.ovalid), 32'd0);
    checkOutput("midreset_count", 32'(bus.count), 32'd0);
    checkOutput("midreset_iafull", 32'(bus.iafull), 32'd0);
    checkOutput("midreset_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clock); #2;
    resetn = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_reset_c2_ovalid", 32'(bus.ovalid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_reset_c3_ovalid", 32'(bus.ovalid), 32'd1);
    checkOutput("post_reset_c3_odata", 32'(bus.odata), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Single word latency.
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
    checkOutput("single_c1_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_c2_ovalid", 32'(bus.ovalid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_c3_ovalid", 32'(bus.ovalid), 32'd1);
    checkOutput("single_c3_odata", 32'(bus.odata), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_c4_count", 32'(bus.count), 32'd0);
    checkOutput("single_c4_ovalid", 32'(bus.ovalid), 32'd0);

    // Fill to capacity with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, (i < 16));
      if (i == 10) checkOutput("afull_below", 32'(bus.iafull), 32'd0);
      if (i == 11) begin
        checkOutput("afull_rise", 32'(bus.iafull), 32'd1);
        checkOutput("afull_count12", 32'(bus.count), 32'd12);
      end
      if (i == 15) begin
        checkOutput("full_count16", 32'(bus.count), 32'd16);
        checkOutput("full_no_overflow", 32'(bus.overflow), 32'd0);
      end
    end
    checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
    checkOutput("overflow_count", 32'(bus.count), 32'd16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Push and transfer together while full, then one below full.
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("simul_full_count", 32'(bus.count), 32'd15);
    checkOutput("simul_full_overflow", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
    checkOutput("simul_15_count", 32'(bus.count), 32'd15);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    drainAll();

    // Streaming across many pointer wraps.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b1);
      if (i >= 2) begin
        checks++;
        if (!(bus.ovalid === 1'b1 && bus.count === 5'd3)) begin
          errors++;
          $display("[TB] FAIL stream_steady: word %0d ovalid=%0b count=%0d required ovalid=1 count=3", i, bus.ovalid, bus.count);
        end
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    drainAll();

    // Random backpressure and random push gaps.
    begin
      int pushed;
      int cyc;
      pushed = 0;
      cyc    = 0;
      while (pushed < 200 && cyc < 5000) begin
        logic rdy;
        logic en;
        rdy = 1'($urandom_range(0, 1));
        en  = ($urandom_range(0, 2) != 0) && !bus.iafull;
        applyStimulus(en, 8'($urandom_range(0, 255)), rdy, 1'b1);
        if (en) pushed++;
        cyc++;
      end
      checkOutput("backpressure_pushed", 32'(pushed), 32'd200);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    drainAll();
    checkOutput("overflow_sticky", 32'(bus.overflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_fifo_ctrl.md
# axis_fifo_ctrl

Control and sequencing block that turns one `dual_port_ram` instance into a complete push-in / AXI-Stream-out FIFO. It owns the write and read pointers and the occupancy counter. It absorbs the RAM's one-cycle read latency with an output register plus a one-entry skid register, and drives the sticky overflow and almost-full flags. It sits between a push-style producer (sampler, packetizer) and an AXIS consumer. The RAM is instantiated by the parent and wired to the `ram_*` ports.

## Interface
- `WIDTH`, 8: data word width.
- `SIZE_LOG2`, 8: log2 of RAM depth. Total FIFO capacity is 2^SIZE_LOG2 words, counting words held in the output stage.
- `AFULL_MARGIN`, 16: `iafull` threshold margin. Legal range is 1 ≤ AFULL_MARGIN < 2^SIZE_LOG2.

Ports:
- `clock`  in  1  single clock for all logic and for both RAM ports.
- `resetn`  in  1  asynchronous, active-low reset.
- `idata`  in  WIDTH  push data.
- `ienable`  in  1  push strobe, one word per cycle. There is no handshake.
- `iafull`  out  1  high while `count` ≥ 2^SIZE_LOG2 − AFULL_MARGIN.
- `overflow`  out  1  sticky flag, set when a push is dropped. Cleared only by reset.
- `count`  out  SIZE_LOG2+1  total occupancy: words accepted but not yet transferred on AXIS.
- `ram_waddr`  out  SIZE_LOG2  RAM write address.
- `ram_wdata`  out  WIDTH  equal to `idata`.
- `ram_wenable`  out  1  RAM write enable.
- `ram_raddr`  out  SIZE_LOG2  RAM read address.
- `ram_rdata`  in  WIDTH  registered RAM read data, valid one cycle after its address.
- `odata`  out  WIDTH  AXIS data.
- `ovalid`  out  1  AXIS valid.
- `oready`  in  1  AXIS ready.

## Operation
- **Pointers.** Write and read pointers are SIZE_LOG2+1 bits wide and wrap naturally. `ram_waddr` and `ram_raddr` are their low SIZE_LOG2 bits. RAM level = wptr − rptr, taken modulo 2^(SIZE_LOG2+1).
- **Push.**
  - full = (`count` == 2^SIZE_LOG2).
  - `ram_wenable` = `ienable` && !full, combinational.
  - An accepted push increments wptr.
  - `ienable` while full drops the word and sets `overflow`. This holds even if an AXIS transfer occurs in the same cycle.
- **Read issue.**
  - p = number of words read-issued but not yet transferred. These words are either in flight, in the skid register or in the output register, so p ∈ {0,1,2}.
  - A read is issued when RAM level ≠ 0 and (p < 2 or (`ovalid` && `oready`)).
  - Issue increments rptr, so `ram_raddr` advances the next cycle, and sets the in-flight flag for one cycle.
  - The RAM reads every cycle. `ram_rdata` is captured only in the cycle the in-flight flag is set.
- **Output stage.** When a captured word arrives:
  - It loads the output register if that register is empty or is transferring this cycle.
  - Otherwise it loads the skid register.
  - When the output register transfers and the skid is full, the skid word moves to the output register, ahead of any arriving word.
  - Word order is strictly preserved.
- **AXIS rules.**
  - `odata` is stable while `ovalid` && !`oready`.
  - `ovalid` never falls without a transfer.
  - A transfer occurs when `ovalid` && `oready` at a rising edge.
- **Count.** `count` is a register: +1 per accepted push, −1 per transfer, unchanged when both occur in the same cycle. `iafull` is combinational from `count`.
- **Wrap-around** is transparent: addresses wrap from 2^SIZE_LOG2−1 to 0 with no bubble.

## Timing
- **Reset.** While `resetn` is low:
  - Pointers, `count`, p, the in-flight flag, the skid and the output register are all zero or empty.
  - `ovalid`=0, `odata`=0, `overflow`=0, `iafull`=0.
  - `ram_wenable` follows `ienable`, since full=0.
  - A reset mid-operation discards all buffered words. RAM contents are not cleared and are never re-read.
- **Latency.** A word pushed in cycle 0 (into an empty FIFO, `oready`=1) is written at the end of cycle 0. Its read issues in cycle 1, it is captured at the end of cycle 2, and it appears with `ovalid`=1 in cycle 3.
- **Throughput.** With `ienable` and `oready` held high, sustained rate is 1 word per cycle after the initial 3-cycle latency.
- **Flag timing.**
  - `iafull` and `count` reflect a push or transfer one cycle after the edge where it occurred.
  - `overflow` rises the cycle after the dropped push.

## Test plan
- **Reset values.** Assert `resetn`=0 mid-stream, then release → `ovalid`=0, `count`=0, `iafull`=0, `overflow`=0. The next push of 0x3C appears on `odata` 3 cycles later as the first word.
- **Single word.** Push 0xA5 in cycle 0 with `oready`=1 → `ovalid`=1, `odata`=0xA5 in cycle 3, and `count` returns to 0 in cycle 4.
- **Almost-full and overflow** (SIZE_LOG2=4, AFULL_MARGIN=4, `oready`=0):
  - Push 0..16 → `iafull` rises after the 12th push, and `count` saturates at 16.
  - The 17th word is dropped and `overflow`=1.
  - Draining then yields exactly 0..15.
- **Streaming and wrap-around.** Hold `ienable`=`oready`=1 for 1000 words with SIZE_LOG2=4 → one word per cycle after latency, in order, with no gaps and `count` ≤ 3.
- **Backpressure.** Randomize `oready` while pushing 200 words with random gaps → no loss or duplication, `odata` stable while stalled, and `ovalid` never drops without a transfer.
- **Simultaneous events.**
  - At `count`=16, assert push and transfer together → push dropped, `overflow`=1, `count`=15.
  - At `count`=15, assert push and transfer together → `count` stays 15.
